// File: rtl/uart2bus_pkg.sv
// uart2bus_pkg: ASCII constants, state enums and hex helpers shared by the UART text bus bridge
package uart2bus_pkg;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_SP  = 8'h20;
    localparam logic [7:0] CH_TAB = 8'h09;
    localparam logic [7:0] CH_R   = 8'h72;
    localparam logic [7:0] CH_W   = 8'h77;

    typedef enum logic [3:0] {
        IDLE, CMD, DATA, SPC2, ADDR, EXEC, RDWAIT, TX_HI, TX_LO, TX_CR, TX_LF
    } pstate_t;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Returns {valid, nibble}; valid is low for any non-hex character.
    function automatic logic [4:0] hex_to_nibble(input logic [7:0] c);
        logic [4:0] r;
        r = 5'h00;
        if (c >= 8'h30 && c <= 8'h39) r = {1'b1, 4'(c - 8'h30)};
        if (c >= 8'h41 && c <= 8'h46) r = {1'b1, 4'(c - 8'h37)};
        if (c >= 8'h61 && c <= 8'h66) r = {1'b1, 4'(c - 8'h57)};
        return r;
    endfunction

    function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
        return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction
endpackage

// File: rtl/uart_text_bus_bridge_uart_core.sv
// uart_core: fractional 16x baud generator with 8N1 receiver and transmitter
// Ports: clock/reset; ser_in/ser_out serial lines; rx_data/rx_valid received byte pulse;
//        tx_data/tx_load byte to send (accepted when !tx_busy); tx_busy high for the whole frame.
module uart_core #(
    parameter int CLK_FREQ_HZ = 40000000,
    parameter int BAUD        = 115200
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ser_in,
    output logic       ser_out,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_busy
);
    import uart2bus_pkg::*;
    localparam logic [31:0] INC = 32'(16 * BAUD);
    localparam logic [31:0] MOD = 32'(CLK_FREQ_HZ);
    logic [31:0] acc_q, acc_d, sum;
    logic        ce16;
    logic        s1_q, s2_q, s3_q;
    rx_state_t   rx_st_q, rx_st_d;
    logic [3:0]  rx_cnt_q, rx_cnt_d, tx_cnt_q, tx_cnt_d, tx_bit_q, tx_bit_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_sh_q, rx_sh_d;
    logic        rx_valid_q, rx_valid_d, tx_busy_q, tx_busy_d;
    logic [9:0]  tx_sh_q, tx_sh_d;

    always_comb begin
        sum = acc_q + INC;
        ce16 = sum >= MOD;
        acc_d = ce16 ? sum - MOD : sum;
    end

    // Receiver: s3 is the previous synchronized sample, used for falling-edge detect.
    always_comb begin
        rx_st_d = rx_st_q;
        rx_cnt_d = ce16 ? rx_cnt_q + 4'd1 : rx_cnt_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d = rx_sh_q;
        rx_valid_d = 1'b0;
        case (rx_st_q)
            RX_IDLE: begin
                rx_cnt_d = 4'd0;
                rx_bit_d = 3'd0;
                if (s3_q && !s2_q) rx_st_d = RX_START;
            end
            RX_START: if (ce16 && rx_cnt_q == 4'd7) begin
                rx_cnt_d = 4'd0;
                rx_st_d = s2_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (ce16 && rx_cnt_q == 4'd15) begin
                rx_sh_d = {s2_q, rx_sh_q[7:1]};
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            default: if (ce16 && rx_cnt_q == 4'd15) begin
                rx_valid_d = s2_q;
                rx_st_d = RX_IDLE;
            end
        endcase
    end

    // Transmitter: shift register holds {stop, data, start}; 10 bits of 16 ticks each.
    always_comb begin
        tx_busy_d = tx_busy_q;
        tx_sh_d = tx_sh_q;
        tx_cnt_d = tx_cnt_q;
        tx_bit_d = tx_bit_q;
        if (!tx_busy_q) begin
            tx_cnt_d = 4'd0;
            tx_bit_d = 4'd0;
            if (tx_load) begin
                tx_busy_d = 1'b1;
                tx_sh_d = {1'b1, tx_data, 1'b0};
            end
        end else if (ce16) begin
            tx_cnt_d = tx_cnt_q + 4'd1;
            if (tx_cnt_q == 4'd15) begin
                tx_sh_d = {1'b1, tx_sh_q[9:1]};
                tx_bit_d = tx_bit_q + 4'd1;
                if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q <= '0;
            {s1_q, s2_q, s3_q} <= 3'b111;
            rx_st_q <= RX_IDLE;
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_sh_q <= '0;
            rx_valid_q <= 1'b0;
            tx_busy_q <= 1'b0;
            tx_sh_q <= '1;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
        end else begin
            acc_q <= acc_d;
            {s1_q, s2_q, s3_q} <= {ser_in, s1_q, s2_q};
            rx_st_q <= rx_st_d;
            rx_cnt_q <= rx_cnt_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q <= rx_sh_d;
            rx_valid_q <= rx_valid_d;
            tx_busy_q <= tx_busy_d;
            tx_sh_q <= tx_sh_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
        end
    end

    assign ser_out = tx_busy_q ? tx_sh_q[0] : 1'b1;
    assign tx_busy = tx_busy_q;
    assign rx_data = rx_sh_q;
    assign rx_valid = rx_valid_q;
endmodule

// File: rtl/uart_text_bus_bridge.sv
// uart_text_bus_bridge: ASCII "w <data> <addr>" / "r <addr>" UART commands to a register bus
// Ports: clock/reset; ser_in/ser_out UART lines; int_address/int_wr_data/int_write/int_read bus
//        outputs; int_rd_data read data valid the cycle after int_read.
// Build option: define UART2BUS_ECHO_EN to echo received bytes while a command is being parsed.
module uart_text_bus_bridge #(
    parameter int CLK_FREQ_HZ = 40000000,
    parameter int BAUD        = 115200,
    parameter int AW          = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ser_in,
    output logic          ser_out,
    output logic [AW-1:0] int_address,
    output logic [7:0]    int_wr_data,
    output logic          int_write,
    output logic          int_read,
    input  logic [7:0]    int_rd_data
);
    import uart2bus_pkg::*;
    logic [7:0]    rx_data, tx_data;
    logic          rx_valid, tx_load, tx_busy;
    pstate_t       st_q, st_d;
    logic          rd_q, rd_d, sep_q, sep_d;
    logic [7:0]    data_q, data_d, rdv_q, rdv_d, wdata_q, wdata_d;
    logic [AW-1:0] addr_q, addr_d, iaddr_q, iaddr_d;
    logic [4:0]    hx;
    logic          is_ws, is_eol;

    uart_core #(.CLK_FREQ_HZ(CLK_FREQ_HZ), .BAUD(BAUD)) u_core (
        .clock(clock), .reset(reset), .ser_in(ser_in), .ser_out(ser_out),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_load(tx_load), .tx_busy(tx_busy)
    );

    // Hex fields shift in from the right; older digits fall off the top.
    always_comb begin
        hx = hex_to_nibble(rx_data);
        is_ws = rx_data == CH_SP || rx_data == CH_TAB;
        is_eol = rx_data == CH_CR || rx_data == CH_LF;
        st_d = st_q;
        rd_d = rd_q;
        sep_d = sep_q;
        data_d = data_q;
        addr_d = addr_q;
        rdv_d = rdv_q;
        wdata_d = wdata_q;
        iaddr_d = iaddr_q;
        tx_load = 1'b0;
        tx_data = 8'h00;
        case (st_q)
            IDLE: if (rx_valid && ((rx_data | 8'h20) == CH_W || (rx_data | 8'h20) == CH_R)) begin
                st_d = CMD;
                rd_d = (rx_data | 8'h20) == CH_R;
                sep_d = 1'b0;
                data_d = 8'h00;
                addr_d = '0;
            end
            CMD: if (rx_valid) begin
                if (is_ws) sep_d = 1'b1;
                else if (hx[4] && sep_q && rd_q) begin
                    st_d = ADDR;
                    addr_d = AW'({addr_q, hx[3:0]});
                end else if (hx[4] && sep_q) begin
                    st_d = DATA;
                    data_d = {data_q[3:0], hx[3:0]};
                end else st_d = IDLE;
            end
            DATA: if (rx_valid) begin
                if (hx[4]) data_d = {data_q[3:0], hx[3:0]};
                else st_d = is_ws ? SPC2 : IDLE;
            end
            SPC2: if (rx_valid && !is_ws) begin
                st_d = hx[4] ? ADDR : IDLE;
                addr_d = AW'({addr_q, hx[3:0]});
            end
            ADDR: if (rx_valid) begin
                if (hx[4]) addr_d = AW'({addr_q, hx[3:0]});
                else if (is_eol) begin
                    st_d = EXEC;
                    iaddr_d = addr_q;
                    wdata_d = rd_q ? wdata_q : data_q;
                end else st_d = IDLE;
            end
            EXEC: st_d = rd_q ? RDWAIT : IDLE;
            RDWAIT: begin
                rdv_d = int_rd_data;
                st_d = TX_HI;
            end
            TX_HI: if (!tx_busy) begin
                tx_load = 1'b1;
                tx_data = nibble_to_ascii(rdv_q[7:4]);
                st_d = TX_LO;
            end
            TX_LO: if (!tx_busy) begin
                tx_load = 1'b1;
                tx_data = nibble_to_ascii(rdv_q[3:0]);
                st_d = TX_CR;
            end
            TX_CR: if (!tx_busy) begin
                tx_load = 1'b1;
                tx_data = CH_CR;
                st_d = TX_LF;
            end
            TX_LF: if (!tx_busy) begin
                tx_load = 1'b1;
                tx_data = CH_LF;
                st_d = IDLE;
            end
            default: st_d = IDLE;
        endcase
`ifdef UART2BUS_ECHO_EN
        if (rx_valid && !tx_busy && st_q inside {IDLE, CMD, DATA, SPC2, ADDR}) begin
            tx_load = 1'b1;
            tx_data = rx_data;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q <= IDLE;
            rd_q <= 1'b0;
            sep_q <= 1'b0;
            data_q <= '0;
            addr_q <= '0;
            rdv_q <= '0;
            wdata_q <= '0;
            iaddr_q <= '0;
        end else begin
            st_q <= st_d;
            rd_q <= rd_d;
            sep_q <= sep_d;
            data_q <= data_d;
            addr_q <= addr_d;
            rdv_q <= rdv_d;
            wdata_q <= wdata_d;
            iaddr_q <= iaddr_d;
        end
    end

    assign int_write = st_q == EXEC && !rd_q;
    assign int_read = st_q == EXEC && rd_q;
    assign int_address = iaddr_q;
    assign int_wr_data = wdata_q;
endmodule

// File: tb/tb_uart_text_bus_bridge.sv
// tb_uart_text_bus_bridge: directed UART command bench with register file model and serial monitor
`timescale 1ns/1ps
module tb_uart_text_bus_bridge;
    localparam realtime BIT = 1.0e9 / 115200.0;
    logic clock = 1'b0, reset = 1'b1, ser_in = 1'b1;
    logic ser_out, int_write, int_read;
    logic [7:0] int_address, int_wr_data, int_rd_data;
    logic [7:0] mem [256];
    logic [7:0] rxq [$];
    logic [7:0] last_wa = 8'h00, last_wd = 8'h00, last_ra = 8'h00;
    int n_tests = 0, n_fail = 0, wr_cnt = 0, rd_cnt = 0, both_cnt = 0;

    always #125 clock = ~clock;

    uart_text_bus_bridge #(.CLK_FREQ_HZ(4000000), .BAUD(115200), .AW(8)) dut (
        .clock(clock), .reset(reset), .ser_in(ser_in), .ser_out(ser_out),
        .int_address(int_address), .int_wr_data(int_wr_data),
        .int_write(int_write), .int_read(int_read), .int_rd_data(int_rd_data)
    );

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            int_rd_data <= 8'h00;
        end else begin
            if (int_write) mem[int_address] <= int_wr_data;
            if (int_read) int_rd_data <= mem[int_address];
        end
    end

    always @(negedge clock) begin
        if (int_write) begin
            wr_cnt++;
            last_wa = int_address;
            last_wd = int_wr_data;
        end
        if (int_read) begin
            rd_cnt++;
            last_ra = int_address;
        end
        if (int_write && int_read) both_cnt++;
    end

    initial forever begin
        logic [7:0] b;
        @(negedge ser_out);
        #(BIT / 2);
        if (ser_out === 1'b0) begin
            for (int i = 0; i < 8; i++) begin
                #(BIT);
                b[i] = ser_out;
            end
            #(BIT);
            rxq.push_back(b);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        ser_in = 1'b0;
        #(BIT);
        for (int i = 0; i < 8; i++) begin
            ser_in = b[i];
            #(BIT);
        end
        ser_in = 1'b1;
        #(BIT);
    endtask

    task automatic send_cmd(input string s, input logic [7:0] term);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
        send_byte(term);
        repeat (20) @(posedge clock);
    endtask

    task automatic expect_reply(input string tag, input logic [7:0] hi, input logic [7:0] lo);
        int k = 0;
        while (rxq.size() < 4 && k < 4000) begin
            @(posedge clock);
            k++;
        end
        check({tag, " reply len"}, rxq.size(), 4);
        if (rxq.size() >= 4) begin
            check({tag, " hi"}, rxq[0], hi);
            check({tag, " lo"}, rxq[1], lo);
            check({tag, " cr"}, rxq[2], 8'h0D);
            check({tag, " lf"}, rxq[3], 8'h0A);
        end
        rxq.delete();
    endtask

    task automatic expect_silence(input string tag);
        repeat (500) @(posedge clock);
        check(tag, rxq.size(), 0);
        rxq.delete();
    endtask

    task automatic pulse_reset_check(input string tag);
        @(posedge clock);
        #1 reset = 1'b1;
        ser_in = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check({tag, " ser_out"}, ser_out, 1);
        check({tag, " int_write"}, int_write, 0);
        check({tag, " int_read"}, int_read, 0);
        check({tag, " int_address"}, int_address, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        #(BIT * 12);
        rxq.delete();
    endtask

    initial begin
        int k;
        repeat (4) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst ser_out", ser_out, 1);
        check("rst int_write", int_write, 0);
        check("rst int_read", int_read, 0);
        check("rst int_address", int_address, 0);
        check("rst int_wr_data", int_wr_data, 0);

        send_cmd("w 4cd9 1a", 8'h0D);
        check("w1 count", wr_cnt, 1);
        check("w1 addr", last_wa, 8'h1A);
        check("w1 data", last_wd, 8'hD9);
        check("w1 no read", rd_cnt, 0);
        check("w1 mem", mem[8'h1A], 8'hD9);
        check("w1 addr hold", int_address, 8'h1A);
        expect_silence("w1 silent");

        send_cmd("r 1a", 8'h0D);
        check("r1 count", rd_cnt, 1);
        check("r1 addr", last_ra, 8'h1A);
        expect_reply("r1", 8'h44, 8'h39);

        send_cmd("R 00", 8'h0D);
        expect_reply("r00", 8'h30, 8'h30);

        send_cmd("W FF 3", 8'h0D);
        check("w2 count", wr_cnt, 2);
        check("w2 addr", last_wa, 8'h03);
        check("w2 data", last_wd, 8'hFF);

        send_cmd("x 12", 8'h0D);
        send_cmd("r", 8'h0D);
        send_cmd("w12 3", 8'h0D);
        send_cmd("r 03 ", 8'h0D);
        check("abort wr", wr_cnt, 2);
        check("abort rd", rd_cnt, 2);
        expect_silence("abort silent");

        send_cmd("r 03", 8'h0D);
        check("r03 count", rd_cnt, 3);
        expect_reply("r03", 8'h46, 8'h46);

        send_cmd("w 123 7ab", 8'h0A);
        check("trunc count", wr_cnt, 3);
        check("trunc addr", last_wa, 8'hAB);
        check("trunc data", last_wd, 8'h23);
        send_cmd("r\t7ab", 8'h0D);
        check("tab addr", last_ra, 8'hAB);
        expect_reply("tab", 8'h32, 8'h33);

        ser_in = 1'b0;
        #(BIT * 3);
        pulse_reset_check("rx reset");
        send_cmd("w 3c 44", 8'h0D);
        check("post rst wr", wr_cnt, 4);
        check("post rst addr", last_wa, 8'h44);
        send_cmd("r 44", 8'h0D);
        check("rd 44 count", rd_cnt, 5);
        k = 0;
        while (ser_out !== 1'b0 && k < 4000) begin
            @(posedge clock);
            k++;
        end
        check("reply start timeout", k < 4000, 1);
        #(BIT * 5);
        pulse_reset_check("tx reset");
        check("tx reset no strobe", rd_cnt, 5);
        send_cmd("r 44", 8'h0D);
        check("rd after rst", rd_cnt, 6);
        expect_reply("rd after rst", 8'h30, 8'h30);

        check("strobe overlap", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_text_bus_bridge.md
Name: uart_text_bus_bridge

Overview:
- Bridges an ASCII command stream on a UART (8N1) to a simple internal register bus.
- Sits between a host serial link and a register file; `reg_file_model` is the companion 256x8 register file used on its bus side.
- Text mode only:
  - "w <data> <addr>" + CR writes one byte.
  - "r <addr>" + CR reads one byte and replies with two uppercase hex digits, CR, LF.

Parameters:
- CLK_FREQ_HZ, 40000000, system clock frequency.
- BAUD, 115200, serial bit rate.
- AW, 8, internal address width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ser_in  in  1  UART receive line, idle high.
- ser_out  out  1  UART transmit line, idle high.
- int_address  out  AW  bus address.
- int_wr_data  out  8  bus write data.
- int_write  out  1  one-cycle write strobe.
- int_read  out  1  one-cycle read strobe.
- int_rd_data  in  8  read data, valid the cycle after int_read.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - ser_out=1, int_write=0, int_read=0, int_address=0, int_wr_data=0.
  - Parser returns to IDLE; rx/tx FSMs return to idle; baud accumulator is cleared.
- Baud generator:
  - Fractional accumulator: add 16*BAUD each cycle; when the sum is >= CLK_FREQ_HZ, subtract CLK_FREQ_HZ and pulse ce16 for one cycle.
  - Result is exact 16x oversampling on average.
- Receiver:
  - Double-flop synchronizer on ser_in.
  - Falling edge starts a frame. The start bit is re-checked at mid-bit (8 ticks); if high, treat it as a false start and return to idle.
  - 8 data bits, LSB first, each sampled at mid-bit.
  - Stop bit is sampled. If low, the byte is dropped; otherwise rx_valid pulses for one cycle with rx_data.
- Transmitter:
  - Frame is start(0), 8 data LSB first, 1 stop(1); 16 ticks per bit.
  - tx_busy is high during the frame; the parser loads a byte only when it is not busy.
- Parser FSM states: IDLE, CMD, DATA, SPC2, ADDR, EXEC, RDWAIT, TX_HI, TX_LO, TX_CR, TX_LF.
- Command and separator rules:
  - IDLE: 'w'/'W' -> CMD (write); 'r'/'R' -> CMD (read); anything else is ignored.
  - CMD: requires one or more spaces (0x20) or tabs (0x09) before the first hex digit.
  - Write: hex digits go to DATA; then one or more spaces -> SPC2; then hex digits go to ADDR.
  - Read: hex digits go directly to ADDR.
- Hex field rules:
  - Digits 0-9, a-f, A-F.
  - Field register = (field<<4)|nibble, truncated to the field width, so excess leading digits are discarded.
  - Example: "4cd9" into 8 bits gives 0xD9.
  - Each field is cleared on entry.
- Termination: CR (0x0D) or LF (0x0A) after at least one address digit -> EXEC.
- Error handling: any other character, or CR before a complete command, aborts to IDLE silently with no bus cycle.
- EXEC, write:
  - int_address=addr, int_wr_data=data, int_write=1 for exactly one cycle.
  - Then IDLE; no serial response.
- EXEC, read:
  - int_address=addr, int_read=1 for one cycle; RDWAIT captures int_rd_data on the next cycle.
  - Then transmit the high nibble and low nibble as uppercase ASCII (nibble<10 ? 0x30+n : 0x37+n), then 0x0D, then 0x0A, each waiting for !tx_busy.
  - Then IDLE.
- Overruns: bytes received while in TX_* states are ignored (no queue).
- Bus outputs: int_address and int_wr_data hold their last values between strobes.
- Strobe exclusivity: int_write and int_read are never high together.
- Companion register file (reg_file_model):
  - 256x8, reset to 0.
  - Writes mem[addr] on int_write.
  - On int_read, registers int_rd_data=mem[addr] at the next edge.

Optional Feature:
- UART2BUS_ECHO_EN defined: every received byte is echoed on ser_out while in IDLE..ADDR states. Echo uses the transmitter when not busy; the byte is dropped if the transmitter is busy.
- Not defined: ser_out carries only read responses.

Decomposition:
- Package uart2bus_pkg:
  - ASCII constants (CR, LF, SP, TAB, 'r', 'w').
  - Parser state enum.
  - Function hex_to_nibble with valid flag; function nibble_to_ascii.
- One natural sub-module: uart_core (baud generator, rx, tx), with ports rx_data/rx_valid and tx_data/tx_load/tx_busy.
- The parser lives in the top module.

Test Plan:
- Send "w 4cd9 1a" CR -> single int_write pulse with int_address=0x1A, int_wr_data=0xD9; no serial output.
- Then send "r 1a" CR -> int_read pulse at address 0x1A; ser_out sends 0x44 ('D'), 0x39 ('9'), 0x0D, 0x0A at 115200 baud.
- "R 00" CR after reset -> reply "00" CR LF. Upper-case commands and "W FF 3" CR -> write 0xFF to 0x03.
- "x 12" CR, or "r" CR with no address -> no bus strobe, no output; a following "r 03" CR still returns "FF".
- Assert reset mid-frame on ser_in and mid-response on ser_out -> ser_out=1 next cycle, no strobes; the next clean command works.
- With UART2BUS_ECHO_EN: "r 1a" CR -> echoes 'r',' ','1','a',CR, then the read reply.
